// File: rtl/layer_sequencer.sv
`default_nettype none
//============================================================================
// Module      : layer_sequencer
// Description : Layer-level scheduler sitting above the core controller.
//               Accepts one convolution-layer descriptor (output channels x
//               input tiles per channel) and issues one core start per
//               (channel, tile) pair, waiting for the core to return idle
//               between starts. Drives the weight/image base addresses and
//               the accumulator-clear flag for each tile, and reports
//               per-channel and per-layer completion.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports:
//   clk           in   1       clock, rising edge
//   rst           in   1       asynchronous reset, active-low
//   cfg_valid     in   1       descriptor valid
//   cfg_ready     out  1       descriptor accepted (high only in IDLE)
//   cfg_num_oc    in   OC_W    output channels per layer
//   cfg_num_tile  in   TILE_W  tiles per output channel
//   cfg_w_base    in   ADDR_W  first weight address
//   cfg_w_stride  in   ADDR_W  weight address step per tile
//   cfg_i_base    in   ADDR_W  first image address
//   cfg_i_stride  in   ADDR_W  image address step per tile
//   abort         in   1       cancel current layer
//   core_idle     in   1       core controller idle flag
//   core_start    out  1       one-cycle start pulse to the core
//   w_addr        out  ADDR_W  weight base for current tile
//   i_addr        out  ADDR_W  image base for current tile
//   acc_clear     out  1       current tile is first of its channel
//   out_valid     out  1       one-cycle pulse, channel out_oc complete
//   out_oc        out  OC_W    index of completed channel
//   busy          out  1       high in every state except IDLE
//   layer_done    out  1       one-cycle pulse, layer complete
//============================================================================
module layer_sequencer #(
    parameter int OC_W   = 8,
    parameter int TILE_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [OC_W-1:0]   cfg_num_oc,
    input  logic [TILE_W-1:0] cfg_num_tile,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_w_stride,
    input  logic [ADDR_W-1:0] cfg_i_base,
    input  logic [ADDR_W-1:0] cfg_i_stride,
    input  logic              abort,
    input  logic              core_idle,
    output logic              core_start,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] i_addr,
    output logic              acc_clear,
    output logic              out_valid,
    output logic [OC_W-1:0]   out_oc,
    output logic              busy,
    output logic              layer_done
);

    //------------------------------------------------------------------------
    // State encoding
    //------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd2;
    localparam logic [2:0] S_ADVANCE   = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_DRAIN     = 3'd5;

    //------------------------------------------------------------------------
    // State, counters, address pointers and latched descriptor
    //------------------------------------------------------------------------
    logic [2:0]        state_q,    state_d;
    logic [OC_W-1:0]   oc_cnt_q,   oc_cnt_d;
    logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
    logic [ADDR_W-1:0] w_addr_q,   w_addr_d;
    logic [ADDR_W-1:0] i_addr_q,   i_addr_d;
    logic [OC_W-1:0]   num_oc_q,   num_oc_d;
    logic [TILE_W-1:0] num_tile_q, num_tile_d;
    logic [ADDR_W-1:0] w_stride_q, w_stride_d;
    logic [ADDR_W-1:0] i_stride_q, i_stride_d;
    logic [ADDR_W-1:0] i_base_q,   i_base_d;

    logic last_tile;
    logic last_oc;

    // Only meaningful once a non-empty descriptor has been latched; the
    // zero-count case never reaches ADVANCE, so the wrap of "0 - 1" is moot.
    assign last_tile = (tile_cnt_q == (num_tile_q - TILE_W'(1)));
    assign last_oc   = (oc_cnt_q   == (num_oc_q   - OC_W'(1)));

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        oc_cnt_d   = oc_cnt_q;
        tile_cnt_d = tile_cnt_q;
        w_addr_d   = w_addr_q;
        i_addr_d   = i_addr_q;
        num_oc_d   = num_oc_q;
        num_tile_d = num_tile_q;
        w_stride_d = w_stride_q;
        i_stride_d = i_stride_q;
        i_base_d   = i_base_q;

        case (state_q)
            S_IDLE: begin
                // abort has no meaning here; only a new descriptor moves us.
                if (cfg_valid) begin
                    num_oc_d   = cfg_num_oc;
                    num_tile_d = cfg_num_tile;
                    w_stride_d = cfg_w_stride;
                    i_stride_d = cfg_i_stride;
                    i_base_d   = cfg_i_base;
                    w_addr_d   = cfg_w_base;
                    i_addr_d   = cfg_i_base;
                    oc_cnt_d   = '0;
                    tile_cnt_d = '0;
                    if ((cfg_num_oc == '0) || (cfg_num_tile == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end

            S_LAUNCH: begin
                // The start pulse itself is combinational; we leave LAUNCH on
                // the same edge that the core registers it.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (core_idle) begin
                    state_d = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                // The core drops idle on the start edge, so the first cycle
                // here already observes it busy; no handshake state needed.
                if (abort) begin
                    state_d = S_DRAIN;
                end else if (core_idle) begin
                    state_d = S_ADVANCE;
                end
            end

            S_ADVANCE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    // Weights are laid out contiguously across channels, so
                    // the weight pointer only ever moves forward.
                    w_addr_d = w_addr_q + w_stride_q;
                    if (!last_tile) begin
                        tile_cnt_d = tile_cnt_q + TILE_W'(1);
                        i_addr_d   = i_addr_q + i_stride_q;
                        state_d    = S_LAUNCH;
                    end else begin
                        // Every channel re-reads the same image tiles.
                        tile_cnt_d = '0;
                        i_addr_d   = i_base_q;
                        if (last_oc) begin
                            state_d = S_DONE;
                        end else begin
                            oc_cnt_d = oc_cnt_q + OC_W'(1);
                            state_d  = S_LAUNCH;
                        end
                    end
                end
            end

            S_DONE: begin
                // Pulse lasts exactly one cycle even if abort is raised here.
                state_d = S_IDLE;
            end

            S_DRAIN: begin
                // Let the in-flight core operation finish before accepting a
                // new descriptor; abort is deliberately ignored.
                if (core_idle) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            oc_cnt_q   <= '0;
            tile_cnt_q <= '0;
            w_addr_q   <= '0;
            i_addr_q   <= '0;
            num_oc_q   <= '0;
            num_tile_q <= '0;
            w_stride_q <= '0;
            i_stride_q <= '0;
            i_base_q   <= '0;
        end else begin
            state_q    <= state_d;
            oc_cnt_q   <= oc_cnt_d;
            tile_cnt_q <= tile_cnt_d;
            w_addr_q   <= w_addr_d;
            i_addr_q   <= i_addr_d;
            num_oc_q   <= num_oc_d;
            num_tile_q <= num_tile_d;
            w_stride_q <= w_stride_d;
            i_stride_q <= i_stride_d;
            i_base_q   <= i_base_d;
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign cfg_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign core_start = (state_q == S_LAUNCH) & core_idle & ~abort;
    assign acc_clear  = ((state_q == S_LAUNCH) || (state_q == S_WAIT_DONE))
                        && (tile_cnt_q == '0);
    assign out_valid  = (state_q == S_ADVANCE) & ~abort & last_tile;
    // oc_cnt only advances on the ADVANCE edge, so it names the channel
    // that is completing during the out_valid cycle.
    assign out_oc     = oc_cnt_q;
    assign layer_done = (state_q == S_DONE);
    assign w_addr     = w_addr_q;
    assign i_addr     = i_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
//============================================================================
// Module      : tb_layer_sequencer
// Description : Self-checking bench for layer_sequencer with a behavioural
//               core model (busy 5 cycles per start) and a scoreboard of
//               expected starts, channel completions and layer completions.
// Revision    : 1.0 - initial release
//============================================================================
module tb_layer_sequencer;

    localparam int OC_W   = 8;
    localparam int TILE_W = 8;
    localparam int ADDR_W = 16;
    localparam int CORE_LAT = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [OC_W-1:0]   cfg_num_oc = '0;
    logic [TILE_W-1:0] cfg_num_tile = '0;
    logic [ADDR_W-1:0] cfg_w_base = '0;
    logic [ADDR_W-1:0] cfg_w_stride = '0;
    logic [ADDR_W-1:0] cfg_i_base = '0;
    logic [ADDR_W-1:0] cfg_i_stride = '0;
    logic              abort = 1'b0;
    logic              core_idle;
    logic              core_start;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] i_addr;
    logic              acc_clear;
    logic              out_valid;
    logic [OC_W-1:0]   out_oc;
    logic              busy;
    logic              layer_done;

    int tests = 0;
    int fails = 0;

    layer_sequencer #(.OC_W(OC_W), .TILE_W(TILE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num_oc(cfg_num_oc), .cfg_num_tile(cfg_num_tile),
        .cfg_w_base(cfg_w_base), .cfg_w_stride(cfg_w_stride),
        .cfg_i_base(cfg_i_base), .cfg_i_stride(cfg_i_stride),
        .abort(abort), .core_idle(core_idle), .core_start(core_start),
        .w_addr(w_addr), .i_addr(i_addr), .acc_clear(acc_clear),
        .out_valid(out_valid), .out_oc(out_oc), .busy(busy),
        .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    // Core model: goes busy on the edge that registers a start.
    int   core_cnt;
    logic hold_low = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst)                core_cnt <= 0;
        else if (core_start)     core_cnt <= CORE_LAT;
        else if (core_cnt != 0)  core_cnt <= core_cnt - 1;
    end
    assign core_idle = (core_cnt == 0) && !hold_low;

    // Scoreboard
    typedef struct {
        logic [ADDR_W-1:0] w;
        logic [ADDR_W-1:0] i;
        logic              clr;
    } start_t;
    start_t          exp_starts[$];
    logic [OC_W-1:0] exp_oc[$];
    int              exp_done = 0;
    start_t          mon_e;
    logic [OC_W-1:0] mon_oc;

    always @(negedge clk) begin
        if (rst) begin
            if (core_start) begin
                tests++;
                if (exp_starts.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_start: got start w=%h i=%h, expected none", w_addr, i_addr);
                end else begin
                    mon_e = exp_starts.pop_front();
                    if (w_addr !== mon_e.w || i_addr !== mon_e.i || acc_clear !== mon_e.clr) begin
                        fails++;
                        $display("FAIL start_fields: got w=%h i=%h clr=%b, expected w=%h i=%h clr=%b",
                                 w_addr, i_addr, acc_clear, mon_e.w, mon_e.i, mon_e.clr);
                    end
                end
            end
            if (out_valid) begin
                tests++;
                if (exp_oc.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out_valid: got out_oc=%0d, expected none", out_oc);
                end else begin
                    mon_oc = exp_oc.pop_front();
                    if (out_oc !== mon_oc) begin
                        fails++;
                        $display("FAIL out_oc: got %0d expected %0d", out_oc, mon_oc);
                    end
                end
            end
            if (layer_done) begin
                tests++;
                if (exp_done == 0) begin
                    fails++;
                    $display("FAIL unexpected_layer_done: got pulse, expected none");
                end else begin
                    exp_done--;
                end
            end
        end
    end

    // Independent reference: build the expected start sequence for a layer.
    task automatic push_layer(input int noc, input int nt,
                              input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] ws,
                              input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] is);
        start_t e;
        logic [ADDR_W-1:0] w;
        w = wb;
        for (int o = 0; o < noc; o++) begin
            for (int t = 0; t < nt; t++) begin
                e.w   = w;
                e.i   = ib + ADDR_W'(t) * is;
                e.clr = (t == 0);
                exp_starts.push_back(e);
                w = w + ws;
            end
        end
    endtask

    // Drives a descriptor for one cycle, then scrambles the cfg bus so any
    // use of unlatched config shows up.
    task automatic send_cfg(input int noc, input int nt,
                            input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] ws,
                            input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] is);
        @(posedge clk); #1;
        cfg_num_oc   = OC_W'(noc);
        cfg_num_tile = TILE_W'(nt);
        cfg_w_base   = wb;
        cfg_w_stride = ws;
        cfg_i_base   = ib;
        cfg_i_stride = is;
        cfg_valid    = 1'b1;
        @(posedge clk); #1;
        cfg_valid    = 1'b0;
        cfg_num_oc   = OC_W'($urandom);
        cfg_num_tile = TILE_W'($urandom);
        cfg_w_base   = ADDR_W'($urandom);
        cfg_w_stride = ADDR_W'($urandom);
        cfg_i_base   = ADDR_W'($urandom);
        cfg_i_stride = ADDR_W'($urandom);
    endtask

    task automatic test_reset();
        tests++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_busy: got ready=%b busy=%b, expected 1/0", cfg_ready, busy);
        end
        tests++;
        if (core_start !== 1'b0 || out_valid !== 1'b0 || layer_done !== 1'b0 || acc_clear !== 1'b0) begin
            fails++;
            $display("FAIL reset_pulses: got start=%b ov=%b done=%b clr=%b, expected 0", core_start, out_valid, layer_done, acc_clear);
        end
        tests++;
        if (w_addr !== '0 || i_addr !== '0 || out_oc !== '0) begin
            fails++;
            $display("FAIL reset_addr: got w=%h i=%h oc=%h, expected 0", w_addr, i_addr, out_oc);
        end
    endtask

    task automatic test_basic_layer();
        int n = 0;
        bit got = 0;
        push_layer(2, 3, 16'h0100, 16'h0010, 16'h0400, 16'h0040);
        exp_oc.push_back(8'd0);
        exp_oc.push_back(8'd1);
        exp_done = 1;
        send_cfg(2, 3, 16'h0100, 16'h0010, 16'h0400, 16'h0040);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (core_start) n++;
            if (layer_done) begin got = 1; break; end
        end
        tests++;
        if (!got) begin fails++; $display("FAIL basic_timeout: got no layer_done, expected one"); end
        tests++;
        if (n != 6) begin fails++; $display("FAIL basic_start_count: got %0d expected 6", n); end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_idle_after: got busy=%b ready=%b, expected 0/1", busy, cfg_ready);
        end
        tests++;
        if (exp_starts.size() != 0 || exp_oc.size() != 0 || exp_done != 0) begin
            fails++;
            $display("FAIL basic_leftover: got starts=%0d oc=%0d done=%0d pending, expected 0",
                     exp_starts.size(), exp_oc.size(), exp_done);
        end
    endtask

    task automatic test_empty_layer();
        exp_done = 1;
        send_cfg(0, 5, 16'h1234, 16'h0001, 16'h2345, 16'h0001);
        tests++;
        if (layer_done !== 1'b1 || core_start !== 1'b0) begin
            fails++;
            $display("FAIL empty_done_pulse: got done=%b start=%b, expected 1/0", layer_done, core_start);
        end
        @(posedge clk); #1;
        tests++;
        if (layer_done !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL empty_return: got done=%b ready=%b, expected 0/1", layer_done, cfg_ready);
        end
        repeat (3) @(posedge clk);
        tests++;
        if (exp_done != 0) begin fails++; $display("FAIL empty_leftover: got %0d pending, expected 0", exp_done); end
    endtask

    task automatic test_idle_hold();
        int n = 0;
        bit got = 0;
        hold_low = 1'b1;
        push_layer(1, 1, 16'h0020, 16'h0004, 16'h0030, 16'h0008);
        exp_oc.push_back(8'd0);
        exp_done = 1;
        send_cfg(1, 1, 16'h0020, 16'h0004, 16'h0030, 16'h0008);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if (core_start !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL hold_no_start: got start=%b busy=%b, expected 0/1", core_start, busy);
            end
        end
        @(posedge clk); #1;
        hold_low = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (core_start) n++;
            if (layer_done) begin got = 1; break; end
        end
        tests++;
        if (!got || n != 1) begin
            fails++;
            $display("FAIL hold_one_start: got starts=%0d done=%b, expected 1/1", n, got);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        bit got = 0;
        push_layer(1, 2, 16'h0800, 16'h0002, 16'h0900, 16'h0003);
        send_cfg(1, 3, 16'h0800, 16'h0002, 16'h0900, 16'h0003);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (core_start) n++;
            if (n == 2) break;
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tests++;
        if (busy !== 1'b1 || core_idle !== 1'b0) begin
            fails++;
            $display("FAIL abort_drain: got busy=%b core_idle=%b, expected 1/0", busy, core_idle);
        end
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (core_idle) begin got = 1; break; end
        end
        tests++;
        if (!got || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_wait_idle: got idle=%b busy=%b, expected 1/1", got, busy);
        end
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL abort_return: got busy=%b ready=%b, expected 0/1", busy, cfg_ready);
        end
        repeat (10) @(posedge clk);
        tests++;
        if (exp_starts.size() != 0 || n != 2) begin
            fails++;
            $display("FAIL abort_starts: got seen=%0d pending=%0d, expected 2/0", n, exp_starts.size());
        end
    endtask

    task automatic test_addr_wrap();
        logic [ADDR_W-1:0] wa[2];
        int n = 0;
        bit got = 0;
        push_layer(1, 2, 16'hFFF0, 16'h0010, 16'h0000, 16'h0100);
        exp_oc.push_back(8'd0);
        exp_done = 1;
        send_cfg(1, 2, 16'hFFF0, 16'h0010, 16'h0000, 16'h0100);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (core_start) begin
                if (n < 2) wa[n] = w_addr;
                n++;
            end
            if (layer_done) begin got = 1; break; end
        end
        tests++;
        if (!got || n != 2 || wa[1] !== 16'h0000) begin
            fails++;
            $display("FAIL wrap_w_addr: got starts=%0d second_w=%h, expected 2/0000", n, wa[1]);
        end
    endtask

    task automatic test_reset_mid_layer();
        int n = 0;
        bit got = 0;
        push_layer(1, 2, 16'h0200, 16'h0008, 16'h0500, 16'h0020);
        exp_oc.push_back(8'd0);
        exp_done = 1;
        send_cfg(1, 2, 16'h0200, 16'h0008, 16'h0500, 16'h0020);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (core_start) break;
        end
        @(posedge clk); #3;
        rst = 1'b0;
        exp_starts.delete();
        exp_oc.delete();
        exp_done = 0;
        #1;
        tests++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || w_addr !== '0 || i_addr !== '0 || acc_clear !== 1'b0 || core_start !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outputs: got busy=%b ready=%b w=%h i=%h clr=%b start=%b, expected 0/1/0/0/0/0",
                     busy, cfg_ready, w_addr, i_addr, acc_clear, core_start);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        push_layer(2, 2, 16'h3000, 16'h0100, 16'h4000, 16'h0200);
        exp_oc.push_back(8'd0);
        exp_oc.push_back(8'd1);
        exp_done = 1;
        send_cfg(2, 2, 16'h3000, 16'h0100, 16'h4000, 16'h0200);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (core_start) n++;
            if (layer_done) begin got = 1; break; end
        end
        tests++;
        if (!got || n != 4) begin
            fails++;
            $display("FAIL midreset_rerun: got starts=%0d done=%b, expected 4/1", n, got);
        end
        repeat (2) @(posedge clk);
        tests++;
        if (exp_starts.size() != 0 || exp_oc.size() != 0 || exp_done != 0) begin
            fails++;
            $display("FAIL midreset_leftover: got starts=%0d oc=%0d done=%0d pending, expected 0",
                     exp_starts.size(), exp_oc.size(), exp_done);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        test_basic_layer();
        test_empty_layer();
        test_idle_hold();
        test_abort();
        test_addr_wrap();
        test_reset_mid_layer();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
